seq_det_scheduler: RTL and testbench

//  Word-level controller for the 4-bit Mealy sequence detector (from reset it flags 0111, 1011, 1100 on bit 4).
//  - Accepts parallel words on a valid/ready input and serialises them MSB-first onto the detector input.
//  - Frames each word into GROUP_LEN-bit groups and clears the detector before every group.
//  - Samples det_dec on the last bit of each group and returns a per-group hit bitmap on a valid/ready output.

---
 rtl/seq_det_scheduler.sv | 152 +++++++++++++++
 tb/tb_seq_det_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: word-level controller for a 4-bit Mealy sequence detector.
// Accepts parallel words on a valid/ready input and splits each word into
// GROUP_LEN-bit groups. Groups are sent MSB-first to the detector, and the
// detector is cleared before every group. The result is one hit bit per group,
// returned on a valid/ready output.
// Optional feature: define SEQ_DET_SCHED_STATS_EN to build a saturating
// counter of matched groups (hit_cnt, cleared by hit_clr).
// Without the macro, hit_cnt is tied to zero.
module seq_det_scheduler #(
  parameter int WORD_W    = 8,
  parameter int GROUP_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WORD_W-1:0]           s_data,
  output logic                        det_in,
  output logic                        det_rst_n,
  input  logic                        det_dec,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WORD_W/GROUP_LEN-1:0] m_hits,
  output logic                        busy,
  input  logic                        hit_clr,
  output logic [CNT_W-1:0]            hit_cnt
);

  localparam int G     = WORD_W / GROUP_LEN;
  localparam int BIT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam int GRP_W = (G > 1) ? $clog2(G) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(GROUP_LEN - 1);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(G - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [WORD_W-1:0] shift_q,   shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GRP_W-1:0]  grp_cnt_q, grp_cnt_d;
  logic [G-1:0]      hits_q,    hits_d;

  // Next state: accept a word, then repeat (clear detector, shift L bits) per group.
  always_comb begin
    // NOTE: every signal gets a default first, so no branch can leave it unassigned and infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    grp_cnt_d = grp_cnt_q;
    hits_d    = hits_q;

    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          shift_d   = s_data;
          hits_d    = '0;
          bit_cnt_d = '0;
          grp_cnt_d = '0;
          state_d   = CLR;
        end
      end

      CLR: state_d = SHIFT;

      SHIFT: begin
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          // The detector's Mealy output is only meaningful on the last bit of a group.
          hits_d[LAST_GRP - grp_cnt_q] = det_dec;
          bit_cnt_d = '0;
          if (grp_cnt_q == LAST_GRP) begin
            state_d = DONE;
          end else begin
            grp_cnt_d = grp_cnt_q + 1'b1;
            state_d   = CLR;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (m_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; a reset mid-word discards any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: shift_q and hits_q are reset along with the control flops, so m_hits reads 0 out of reset.
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      grp_cnt_q <= '0;
      hits_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      grp_cnt_q <= grp_cnt_d;
      hits_q    <= hits_d;
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign m_valid   = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign m_hits    = hits_q;
  assign det_in    = (state_q == SHIFT) & shift_q[WORD_W-1];
  // The detector follows our own reset and gets a one-cycle clear before each group.
  assign det_rst_n = rst_n & (state_q != CLR);

`ifdef SEQ_DET_SCHED_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W:0]   hit_sum;

  // Saturating count of matched groups; a clear wins over a same-cycle increment.
  always_comb begin
    hit_sum   = {1'b0, hit_cnt_q} + (CNT_W+1)'($countones(hits_q));
    hit_cnt_d = hit_cnt_q;
    if (hit_clr) begin
      hit_cnt_d = '0;
    end else if (m_valid && m_ready) begin
      hit_cnt_d = hit_sum[CNT_W] ? '1 : hit_sum[CNT_W-1:0];
    end
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`else
  logic unused_hit_clr;
  assign unused_hit_clr = hit_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: self-checking bench for seq_det_scheduler.
// Contains a behavioural 4-bit Mealy detector that flags 0111, 1011 and 1100
// on the 4th bit after its reset. Also contains a word-level reference model
// for expected hits and the statistics counter.
module tb_seq_det_scheduler;

  localparam int WORD_W    = 8;
  localparam int GROUP_LEN = 4;
  localparam int CNT_W     = 8;
  localparam int G         = WORD_W / GROUP_LEN;
  localparam int LATENCY   = G * (GROUP_LEN + 1);
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef SEQ_DET_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              det_in;
  logic              det_rst_n;
  logic              det_dec;
  logic              m_valid;
  logic              m_ready;
  logic [G-1:0]      m_hits;
  logic              busy;
  logic              hit_clr;
  logic [CNT_W-1:0]  hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  seq_det_scheduler #(
    .WORD_W   (WORD_W),
    .GROUP_LEN(GROUP_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .det_in   (det_in),
    .det_rst_n(det_rst_n),
    .det_dec  (det_dec),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_hits   (m_hits),
    .busy     (busy),
    .hit_clr  (hit_clr),
    .hit_cnt  (hit_cnt)
  );

  // Behavioural detector: remembers the last 3 bits and how many bits arrived since its reset.
  logic [2:0] det_hist;
  logic [2:0] det_seen;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      det_hist <= '0;
      det_seen <= '0;
    end else begin
      det_hist <= {det_hist[1:0], det_in};
      if (det_seen != 3'd4) det_seen <= det_seen + 3'd1;
    end
  end

  always_comb begin
    det_dec = 1'b0;
    if (det_seen == 3'd3) begin
      case ({det_hist, det_in})
        4'b0111, 4'b1011, 4'b1100: det_dec = 1'b1;
        default: det_dec = 1'b0;
      endcase
    end
  end

  // Reference: a group hits when its nibble is one of the detector patterns.
  function automatic logic [G-1:0] model_hits(input logic [WORD_W-1:0] w);
    logic [G-1:0] r;
    logic [GROUP_LEN-1:0] nib;
    r = '0;
    for (int g = 0; g < G; g++) begin
      nib  = w[g*GROUP_LEN +: GROUP_LEN];
      r[g] = (nib == 4'h7) || (nib == 4'hB) || (nib == 4'hC);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for m_valid after an accept edge and checks latency and hits.
  task automatic wait_result(input string tag, input logic [G-1:0] exp_hits);
    int lat;
    lat = 0;
    while (!m_valid && lat < 4 * LATENCY) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, LATENCY);
    check({tag, " m_hits"}, m_hits, exp_hits);
  endtask

  // Accepts the pending result, updates the counter model and checks the return to IDLE.
  task automatic accept_result(input logic [G-1:0] exp_hits, input bit clr, input string tag);
    m_ready = 1'b1;
    hit_clr = clr;
    tick();
    m_ready = 1'b0;
    hit_clr = 1'b0;
    if (STATS) begin
      if (clr) exp_cnt = 0;
      else     exp_cnt = (exp_cnt + $countones(exp_hits) > CNT_MAX) ? CNT_MAX
                                                                     : exp_cnt + $countones(exp_hits);
    end
    check({tag, " hit_cnt"}, hit_cnt, exp_cnt);
    check({tag, " m_valid drop"}, m_valid, 0);
    check({tag, " s_ready back"}, s_ready, 1);
  endtask

  task automatic run_word(input logic [WORD_W-1:0] w, input logic [G-1:0] exp_hits,
                          input int stall, input bit clr, input string tag);
    check({tag, " s_ready idle"}, s_ready, 1);
    s_data  = w;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    wait_result(tag, exp_hits);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " held"}, {m_valid, m_hits}, {1'b1, exp_hits});
    end
    accept_result(exp_hits, clr, tag);
  endtask

  typedef struct {
    logic [WORD_W-1:0] word;
    logic [G-1:0]      hits;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [WORD_W-1:0] w;
    logic              seen;

    vecs[0] = '{8'hC0, 2'b10};
    vecs[1] = '{8'h0C, 2'b01};
    vecs[2] = '{8'hFF, 2'b00};
    vecs[3] = '{8'h7B, 2'b11};
    vecs[4] = '{8'hB7, 2'b11};
    vecs[5] = '{8'h00, 2'b00};
    vecs[6] = '{8'h7C, 2'b11};
    vecs[7] = '{8'h17, 2'b01};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    hit_clr = 1'b0;

    // Reset state, observed while rst_n is still low
    repeat (2) tick();
    check("reset s_ready", s_ready, 1);
    check("reset m_valid", m_valid, 0);
    check("reset det_rst_n", det_rst_n, 0);
    check("reset busy", busy, 0);
    check("reset hit_cnt", hit_cnt, 0);
    check("reset m_hits", m_hits, 0);
    check("reset det_in", det_in, 0);
    rst_n = 1'b1;
    tick();
    check("idle det_rst_n", det_rst_n, 1);
    check("idle s_ready", s_ready, 1);

    // Cycle-by-cycle trace of 8'h7B: clear slot, then 4 bits MSB-first, for each group
    w       = 8'h7B;
    s_data  = w;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k <= LATENCY; k++) begin
      int   p;
      int   g;
      logic exp_in;
      logic exp_rst;
      p = k % (GROUP_LEN + 1);
      g = G - 1 - k / (GROUP_LEN + 1);
      if (k == LATENCY) begin
        exp_in  = 1'b0;
        exp_rst = 1'b1;
      end else if (p == 0) begin
        exp_in  = 1'b0;
        exp_rst = 1'b0;
      end else begin
        exp_in  = w[g*GROUP_LEN + GROUP_LEN - p];
        exp_rst = 1'b1;
      end
      check("trace det_in", det_in, exp_in);
      check("trace det_rst_n", det_rst_n, exp_rst);
      check("trace m_valid", m_valid, (k == LATENCY));
      check("trace busy", busy, 1);
      if (k < LATENCY) tick();
    end
    check("trace m_hits", m_hits, 2'b11);
    accept_result(2'b11, 1'b0, "trace");

    // Table-driven words
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].word, vecs[i].hits, i % 3, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-pressure: result held, input ignored, while m_ready stays low
    s_data  = 8'h7B;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    wait_result("stall", 2'b11);
    s_valid = 1'b1;
    s_data  = 8'hC0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall m_valid", m_valid, 1);
      check("stall m_hits", m_hits, 2'b11);
      check("stall s_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    accept_result(2'b11, 1'b0, "stall release");
    check("stall release busy", busy, 0);

    // Randomized words against the reference model
    for (int i = 0; i < 40; i++) begin
      w = WORD_W'($urandom);
      run_word(w, model_hits(w), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
               $sformatf("rand%0d w=%0h", i, w));
    end

    // Counter saturation
    for (int i = 0; i < 130; i++) begin
      run_word(8'h7B, 2'b11, 0, 1'b0, "sat");
    end
    check("saturated hit_cnt", hit_cnt, STATS ? CNT_MAX : 0);

    // Reset during the second group aborts the word
    s_data  = 8'h7B;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    check("midreset det_rst_n", det_rst_n, 0);
    check("midreset busy", busy, 0);
    check("midreset m_valid", m_valid, 0);
    check("midreset hit_cnt", hit_cnt, 0);
    rst_n   = 1'b1;
    exp_cnt = 0;
    seen    = 1'b0;
    repeat (15) begin
      tick();
      if (m_valid) seen = 1'b1;
    end
    check("midreset no partial result", seen, 0);
    run_word(8'hC0, 2'b10, 0, 1'b0, "post-reset C0");

    // Statistics: fresh count over 7B, C0, FF, then a clear on an accepted result
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    exp_cnt = 0;
    tick();
    run_word(8'h7B, 2'b11, 0, 1'b0, "stats 7B");
    run_word(8'hC0, 2'b10, 1, 1'b0, "stats C0");
    run_word(8'hFF, 2'b00, 0, 1'b0, "stats FF");
    check("stats total", hit_cnt, STATS ? 3 : 0);
    run_word(8'h7B, 2'b11, 2, 1'b1, "stats clr");
    check("stats cleared", hit_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
